xgmii_channel_model: RTL
========================

Name: xgmii_channel_model

Overview:
- Synthesizable, parametrised XGMII channel placed between the MAC XGMII transmit and receive ports. It replaces a plain TX-to-RX wire loopback.
- Adds a programmable delay, forced link-state modes (idle, local fault, remote fault), single-shot /E/ error injection, and frame and error counters.
- Runs on the XGMII clock domain only. It is configured by the test environment or a register shim.

Parameters:
- LANES, 8, number of XGMII byte lanes. Legal values are 4 and 8. DATA_W = 8*LANES.
- MAX_DELAY, 16, depth of the delay line. Must be a power of 2, at least 2. DLY_W = $clog2(MAX_DELAY).
- CNT_W, 16, width of the frame and error counters.

Ports:
- clk_xgmii  in  1  XGMII clock; all logic is on the rising edge.
- reset_xgmii  in  1  synchronous reset, active-high.
- xgmii_txd  in  DATA_W  TX data from the MAC. Lane n occupies bits [8n+7:8n].
- xgmii_txc  in  LANES  TX control, one bit per lane.
- xgmii_rxd  out  DATA_W  RX data to the MAC.
- xgmii_rxc  out  LANES  RX control to the MAC.
- cfg_mode  in  2  0=PASS, 1=LOCAL_FAULT, 2=REMOTE_FAULT, 3=IDLE. Sampled every cycle.
- cfg_delay  in  DLY_W  delay selection. Used only when cfg_load is pulsed.
- cfg_load  in  1  one-cycle pulse: latch cfg_delay and start a flush.
- inj_req  in  1  one-cycle pulse: arm a single error injection.
- inj_lane  in  $clog2(LANES)  lane to corrupt. Captured together with inj_req.
- inj_busy  out  1  injection is armed and not yet applied.
- flush_busy  out  1  output is forced to idle during a flush.
- frame_cnt  out  CNT_W  count of start characters seen at the input. Saturates.
- err_cnt  out  CNT_W  count of injections applied. Saturates.

Behaviour:
- Reset: all of the following take effect on the next clock edge with reset_xgmii high.
  - xgmii_rxd = {LANES{8'h07}} and xgmii_rxc = all ones (IDLE).
  - Every delay-line stage is loaded with IDLE.
  - active_delay=0, inj_busy=0, flush_busy=0, frame_cnt=0, err_cnt=0.
- Reset mid-frame discards all in-flight words and clears arming; no partial frame reaches the output.
- Start detection: a start is lane 0 with txc[0]=1 and data 8'hFB. When LANES=8, lane 4 with txc[4]=1 and data 8'hFB also counts. At most one start is counted per cycle.
- Delay line:
  - Input word is {txc, txd} after injection. It shifts one stage per cycle.
  - The output tap is stage active_delay, so latency from xgmii_txd to xgmii_rxd is active_delay+1 cycles. The range is 1..MAX_DELAY.
- cfg_load:
  - In the cycle cfg_load is seen, active_delay <= cfg_delay and a flush counter is loaded with MAX_DELAY.
  - flush_busy=1 while the counter is non-zero. During that time the output is forced to IDLE regardless of cfg_mode.
  - A new cfg_load during a flush reloads both active_delay and the counter.
- Output select, applied after the tap, in priority order:
  1. flush → IDLE.
  2. LOCAL_FAULT → each 4-lane group carries {8'h01,8'h00,8'h00,8'h9C} with ctrl 4'b0001.
  3. REMOTE_FAULT → same pattern with 8'h02 in place of 8'h01.
  4. IDLE → IDLE.
  5. PASS → tap word.
- The delay line keeps shifting in all modes. A mode change takes effect on the next output cycle, with no alignment to frames.
- Injection state machine, states ARMED_IDLE → ARMED → HIT → ARMED_IDLE:
  - inj_req in ARMED_IDLE goes to ARMED, latches inj_lane, and sets inj_busy=1.
  - inj_req while ARMED or HIT is ignored.
  - In ARMED, a start detected at the input goes to HIT.
  - In HIT, the current input word has its selected lane replaced with data 8'hFE, ctrl 1. Then err_cnt increments and the state returns to ARMED_IDLE (inj_busy=0).
  - If inj_req and a start occur in the same cycle, the start does not trigger HIT; injection waits for the next start.
- Counters increment by 1 per event and hold at all ones. They are unaffected by cfg_mode and flush.

Test Plan:
- Reset, then PASS with cfg_load at cfg_delay=3. A frame is driven starting with lane0=FB/ctrl1. → rxd shows IDLE for 16 cycles, then the frame appears 4 cycles after input; frame_cnt=1.
- PASS with delay 0 and a 3-word frame. inj_req pulses with inj_lane=2 before the start. → the word after the start has lane 2 = FE/ctrl1 at the output; err_cnt=1; inj_busy falls in the HIT cycle.
- inj_req pulsed twice while armed, then two frames. → exactly one corruption, in the first frame only; err_cnt=1.
- cfg_mode=1 with traffic flowing. → rxd=64'h0100009C_0100009C, rxc=8'h11 from the next output cycle. Switching cfg_mode=2 → 64'h0200009C_0200009C.
- LANES=8, start in lane 4 with lane 0 idle. → frame_cnt increments. cfg_load issued at cycle 5 of a flush → flush_busy stays high 16 cycles from the second load.
- reset_xgmii asserted mid-frame while armed. → next cycle rxd=IDLE, inj_busy=0, counters=0; the remaining frame never reaches the output.

Source files
------------

// File: rtl/xgmii_channel_model.sv
// XGMII channel model: sits between the MAC transmit and receive XGMII ports.
// Provides a programmable delay line, forced link states (local fault,
// remote fault, idle), single-shot /E/ error injection, and saturating
// frame/error counters. Everything runs on clk_xgmii.
module xgmii_channel_model #(
   parameter int LANES     = 8,
   parameter int MAX_DELAY = 16,
   parameter int CNT_W     = 16,
   localparam int DATA_W   = 8 * LANES,
   localparam int DLY_W    = $clog2(MAX_DELAY),
   localparam int LANE_W   = $clog2(LANES)
) (
   input  logic              clk_xgmii,
   input  logic              reset_xgmii,
   input  logic [DATA_W-1:0] xgmii_txd,
   input  logic [LANES-1:0]  xgmii_txc,
   output logic [DATA_W-1:0] xgmii_rxd,
   output logic [LANES-1:0]  xgmii_rxc,
   input  logic [1:0]        cfg_mode,
   input  logic [DLY_W-1:0]  cfg_delay,
   input  logic              cfg_load,
   input  logic              inj_req,
   input  logic [LANE_W-1:0] inj_lane,
   output logic              inj_busy,
   output logic              flush_busy,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic [CNT_W-1:0]  err_cnt
);

   localparam int WORD_W = DATA_W + LANES;
   localparam int FL_W   = DLY_W + 1;

   localparam logic [FL_W-1:0] FLUSH_LOAD = FL_W'(MAX_DELAY);

   localparam logic [1:0] MODE_PASS   = 2'd0;
   localparam logic [1:0] MODE_LFAULT = 2'd1;
   localparam logic [1:0] MODE_RFAULT = 2'd2;
   localparam logic [1:0] MODE_IDLE   = 2'd3;

   // Words are packed as {ctrl, data} throughout the datapath.
   localparam logic [WORD_W-1:0] IDLE_WORD   = {{LANES{1'b1}}, {LANES{8'h07}}};
   localparam logic [WORD_W-1:0] LFAULT_WORD = {{(LANES/4){4'b0001}}, {(LANES/4){32'h0100009C}}};
   localparam logic [WORD_W-1:0] RFAULT_WORD = {{(LANES/4){4'b0001}}, {(LANES/4){32'h0200009C}}};

   typedef enum logic [1:0] {
      ARMED_IDLE = 2'd0,
      ARMED      = 2'd1,
      HIT        = 2'd2
   } injState_e;

   injState_e injState_q, injState_d;

   logic [LANE_W-1:0] injLane_q;
   logic [DLY_W-1:0]  activeDelay_q;
   logic [FL_W-1:0]   flushCnt_q, flushCnt_d;
   logic [CNT_W-1:0]  frameCnt_q, errCnt_q;
   logic [WORD_W-1:0] outWord_q, outWord_d;
   logic [WORD_W-1:0] line_q [MAX_DELAY-1];

   logic              lane0Start, lane4Start, startSeen;
   logic [DATA_W-1:0] txdInj;
   logic [LANES-1:0]  txcInj;
   logic [WORD_W-1:0] inWord, tapWord;

   assign lane0Start = xgmii_txc[0] && (xgmii_txd[7:0] == 8'hFB);

   // The second start position only exists on the 8-lane (64-bit) interface.
   generate
      if (LANES == 8) begin : g_lane4Start
         assign lane4Start = xgmii_txc[4] && (xgmii_txd[39:32] == 8'hFB);
      end else begin : g_noLane4Start
         assign lane4Start = 1'b0;
      end
   endgenerate

   assign startSeen = lane0Start || lane4Start;

   // Corrupt the selected lane of the word following the triggering start.
   always_comb begin
      txdInj = xgmii_txd;
      txcInj = xgmii_txc;
      if (injState_q == HIT) begin
         txdInj[8*injLane_q +: 8] = 8'hFE;
         txcInj[injLane_q]        = 1'b1;
      end
   end

   assign inWord = {txcInj, txdInj};

   // Injection sequencing: arm on request, wait for a start, hit the next word.
   always_comb begin
      injState_d = injState_q;
      case (injState_q)
         ARMED_IDLE: if (inj_req) injState_d = ARMED;
         ARMED:      if (startSeen) injState_d = HIT;
         HIT:        injState_d = ARMED_IDLE;
         default:    injState_d = ARMED_IDLE;
      endcase
   end

   // Tap zero is the live input word; tap k is k cycles further back in the line.
   always_comb begin
      tapWord = inWord;
      for (int k = 0; k < MAX_DELAY - 1; k++) begin
         if (activeDelay_q == DLY_W'(k + 1)) tapWord = line_q[k];
      end
   end

   // Flush counter: a load (re)starts it at full depth, otherwise count down to zero.
   always_comb begin
      flushCnt_d = flushCnt_q;
      if (cfg_load) begin
         flushCnt_d = FLUSH_LOAD;
      end else if (flushCnt_q != '0) begin
         flushCnt_d = flushCnt_q - 1'b1;
      end
   end

   // Output select uses the next flush count so the registered output is idle exactly while flush_busy is high.
   always_comb begin
      outWord_d = tapWord;
      if (flushCnt_d != '0) begin
         outWord_d = IDLE_WORD;
      end else begin
         case (cfg_mode)
            MODE_LFAULT: outWord_d = LFAULT_WORD;
            MODE_RFAULT: outWord_d = RFAULT_WORD;
            MODE_IDLE:   outWord_d = IDLE_WORD;
            MODE_PASS:   outWord_d = tapWord;
            default:     outWord_d = tapWord;
         endcase
      end
   end

   // All state: delay line, output register, configuration, injection and counters.
   always_ff @(posedge clk_xgmii) begin
      if (reset_xgmii) begin
         for (int k = 0; k < MAX_DELAY - 1; k++) line_q[k] <= IDLE_WORD;
         outWord_q     <= IDLE_WORD;
         activeDelay_q <= '0;
         flushCnt_q    <= '0;
         injState_q    <= ARMED_IDLE;
         injLane_q     <= '0;
         frameCnt_q    <= '0;
         errCnt_q      <= '0;
      end else begin
         line_q[0] <= inWord;
         for (int k = 1; k < MAX_DELAY - 1; k++) line_q[k] <= line_q[k-1];
         outWord_q  <= outWord_d;
         flushCnt_q <= flushCnt_d;
         injState_q <= injState_d;
         if (cfg_load) activeDelay_q <= cfg_delay;
         if ((injState_q == ARMED_IDLE) && inj_req) injLane_q <= inj_lane;
         if (startSeen && (frameCnt_q != '1)) frameCnt_q <= frameCnt_q + 1'b1;
         if ((injState_q == HIT) && (errCnt_q != '1)) errCnt_q <= errCnt_q + 1'b1;
      end
   end

   assign xgmii_rxd  = outWord_q[DATA_W-1:0];
   assign xgmii_rxc  = outWord_q[WORD_W-1:DATA_W];
   assign inj_busy   = (injState_q == ARMED);
   assign flush_busy = (flushCnt_q != '0);
   assign frame_cnt  = frameCnt_q;
   assign err_cnt    = errCnt_q;

endmodule
